// File: rtl/tpu_pkg.sv
// Shared types and address-map constants for the TPU MMIO sequencer.
package tpu_pkg;

    // Sequencer states: optional C-clear pre-pass, multiply pass, one-cycle completion.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        MUL   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Region selectors, taken from the word address above bit 7.
    localparam logic [7:0] REGION_A   = 8'h01;
    localparam logic [7:0] REGION_B   = 8'h02;
    localparam logic [7:0] REGION_C   = 8'h03;
    localparam logic [7:0] REGION_CTL = 8'h04;

    // Offsets of the control registers inside the control region.
    localparam logic [7:0] OFF_CMD    = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h01;

    // CMD write bits.
    localparam int CMD_START = 0;
    localparam int CMD_CLEAR = 1;

    // STATUS read bits.
    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

endpackage

// File: rtl/tpu_crow_stager.sv
// Packs host words into a full C row for writes and picks one word out of a C row for reads.
// Words below the top one are held in staging; writing the top word commits the row.
module tpu_crow_stager #(
    parameter int DATAW = 64,
    parameter int WPC   = 2,
    parameter int WLW   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_i,
    input  logic [WLW-1:0]       word_i,
    input  logic [DATAW-1:0]     data_i,
    input  logic [WPC*DATAW-1:0] row_data_i,
    output logic                 commit_o,
    output logic [WPC*DATAW-1:0] cin_o,
    output logic [DATAW-1:0]     rd_word_o
);

    // Only the low WPC-1 words ever need storage; the top word comes straight from the bus.
    localparam int SW = (WPC > 1) ? WPC - 1 : 1;

    logic [SW-1:0][DATAW-1:0] stage_q;

    // Latch each non-final word into its own slot, so out-of-order writes land correctly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            for (int w = 0; w < WPC - 1; w++) begin
                if (wr_i && (word_i == WLW'(w))) begin
                    stage_q[w] <= data_i;
                end
            end
        end
    end

    assign commit_o = wr_i && (word_i == WLW'(WPC - 1));

    genvar gi;
    generate
        for (gi = 0; gi < WPC; gi++) begin : g_pack
            if (gi == WPC - 1) begin : g_top
                assign cin_o[gi*DATAW +: DATAW] = data_i;
            end else begin : g_low
                assign cin_o[gi*DATAW +: DATAW] = stage_q[gi];
            end
        end
    endgenerate

    assign rd_word_o = row_data_i[int'(word_i)*DATAW +: DATAW];

endmodule

// File: rtl/tpu_mmio_seq.sv
// Host-facing MMIO decoder and multiply sequencer for the TPU.
// Translates word accesses into memA/memB/systolic-array strobes and runs clear/multiply passes.
module tpu_mmio_seq
    import tpu_pkg::*;
#(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8,
    parameter int ADDRW   = 16,
    parameter int DATAW   = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic                    r_w,
    input  logic [ADDRW-1:0]        addr,
    input  logic [DATAW-1:0]        dataIn,
    output logic [DATAW-1:0]        dataOut,
    output logic                    rsp_valid,
    output logic                    busy,
    output logic                    a_en,
    output logic                    a_wr_en,
    output logic [$clog2(DIM)-1:0]  a_row,
    output logic [DIM*BITS_AB-1:0]  a_in,
    output logic                    b_en,
    output logic [DIM*BITS_AB-1:0]  b_in,
    output logic                    sa_en,
    output logic                    sa_wr_en,
    output logic [$clog2(DIM)-1:0]  sa_crow,
    output logic [DIM*BITS_C-1:0]   sa_cin,
    input  logic [DIM*BITS_C-1:0]   sa_cout
);

    localparam int WPC = DIM * BITS_C / DATAW;
    localparam int RW  = $clog2(DIM);
    localparam int WB  = (WPC > 1) ? $clog2(WPC) : 0;
    localparam int WLW = (WPC > 1) ? WB : 1;
    localparam int CW  = $clog2(3 * DIM);

    localparam logic [CW-1:0] CLR_LAST = CW'(DIM - 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(3 * DIM - 3);
    localparam logic [CW-1:0] ROW_LAST = CW'(DIM - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATAW-1:0]  rd_data_q, rd_data_d;
    logic              rsp_valid_q;

    // ---------------- address decode ----------------
    logic [ADDRW-9:0]  region;
    logic              host_ok, wr, rd;
    logic              hit_a, hit_b, hit_c, hit_cmd, hit_status;
    logic              busy_w, acc_a, acc_b, acc_c, start, viol, status_rd;
    logic [RW-1:0]     c_row;
    logic [WLW-1:0]    c_word;

    // Requests are masked while reset is held so the strobes stay low during reset.
    assign host_ok    = req && !rst;
    assign wr         = host_ok && r_w;
    assign rd         = host_ok && !r_w;
    assign region     = addr[ADDRW-1:8];
    assign hit_a      = (region == (ADDRW-8)'(REGION_A));
    assign hit_b      = (region == (ADDRW-8)'(REGION_B));
    assign hit_c      = (region == (ADDRW-8)'(REGION_C));
    assign hit_cmd    = (region == (ADDRW-8)'(REGION_CTL)) && (addr[7:0] == OFF_CMD);
    assign hit_status = (region == (ADDRW-8)'(REGION_CTL)) && (addr[7:0] == OFF_STATUS);

    assign busy_w     = (state_q != IDLE);
    assign acc_a      = wr && hit_a && !busy_w;
    assign acc_b      = wr && hit_b && !busy_w;
    assign acc_c      = wr && hit_c && !busy_w;
    assign start      = wr && hit_cmd && dataIn[CMD_START] && !busy_w;
    assign viol       = wr && busy_w && (hit_a || hit_b || hit_c || (hit_cmd && dataIn[CMD_START]));
    assign status_rd  = rd && hit_status;

    assign c_row = addr[RW+WB-1:WB];

    generate
        if (WPC > 1) begin : g_word
            assign c_word = addr[WLW-1:0];
        end else begin : g_noword
            assign c_word = '0;
        end
    endgenerate

    logic              c_commit;
    logic [DIM*BITS_C-1:0] c_pack;
    logic [DATAW-1:0]  c_rd_word;

    tpu_crow_stager #(
        .DATAW (DATAW),
        .WPC   (WPC),
        .WLW   (WLW)
    ) u_stager (
        .clk        (clk),
        .rst        (rst),
        .wr_i       (acc_c),
        .word_i     (c_word),
        .data_i     (dataIn),
        .row_data_i (sa_cout),
        .commit_o   (c_commit),
        .cin_o      (c_pack),
        .rd_word_o  (c_rd_word)
    );

    // FSM state, cycle counter, sticky status and registered read response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_data_q   <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rd_data_q   <= rd_data_d;
            rsp_valid_q <= rd;
        end
    end

    // Next state plus the memA/memB/array strobes for the current state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_en     = 1'b0;
        a_wr_en  = 1'b0;
        a_row    = '0;
        a_in     = '0;
        b_en     = 1'b0;
        b_in     = '0;
        sa_en    = 1'b0;
        sa_wr_en = 1'b0;
        sa_crow  = '0;
        sa_cin   = '0;
        unique case (state_q)
            IDLE: begin
                if (acc_a) begin
                    a_en    = 1'b1;
                    a_wr_en = 1'b1;
                    a_row   = addr[RW-1:0];
                    a_in    = dataIn;
                end
                if (acc_b) begin
                    b_en = 1'b1;
                    b_in = dataIn;
                end
                if (host_ok && hit_c) begin
                    sa_crow = c_row;
                end
                if (c_commit) begin
                    sa_wr_en = 1'b1;
                    sa_cin   = c_pack;
                end
                if (start) begin
                    state_d = dataIn[CMD_CLEAR] ? CLEAR : MUL;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                sa_wr_en = 1'b1;
                sa_crow  = cnt_q[RW-1:0];
                if (cnt_q == CLR_LAST) begin
                    state_d = MUL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MUL: begin
                a_en  = 1'b1;
                b_en  = 1'b1;
                sa_en = 1'b1;
                // A rows stream once, then the last row is held while the array drains.
                a_row = (cnt_q > ROW_LAST) ? RW'(DIM - 1) : cnt_q[RW-1:0];
                if (cnt_q == MUL_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky done/err: cleared by a STATUS read or accepted start; a same-cycle set wins.
    always_comb begin
        done_d = done_q;
        err_d  = err_q;
        if (status_rd || start) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (state_q == DONE) begin
            done_d = 1'b1;
        end
        if (viol) begin
            err_d = 1'b1;
        end
    end

    // Read mux; C is hidden while busy and CMD is write-only so it reads as zero.
    always_comb begin
        rd_data_d = '0;
        if (rd) begin
            if (hit_c && !busy_w) begin
                rd_data_d = c_rd_word;
            end else if (hit_status) begin
                rd_data_d[ST_BUSY] = busy_w;
                rd_data_d[ST_DONE] = done_q;
                rd_data_d[ST_ERR]  = err_q;
            end
        end
    end

    assign busy      = busy_w;
    assign dataOut   = rd_data_q;
    assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_tpu_mmio_seq.sv
// Directed bench for tpu_mmio_seq: same-cycle strobe checks plus a read scoreboard.
module tb_tpu_mmio_seq;

    localparam int BITS_AB = 8;
    localparam int BITS_C  = 16;
    localparam int DIM     = 8;
    localparam int ADDRW   = 16;
    localparam int DATAW   = 64;
    localparam int RW      = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   req;
    logic                   r_w;
    logic [ADDRW-1:0]       addr;
    logic [DATAW-1:0]       dataIn;
    logic [DATAW-1:0]       dataOut;
    logic                   rsp_valid;
    logic                   busy;
    logic                   a_en, a_wr_en;
    logic [RW-1:0]          a_row;
    logic [DIM*BITS_AB-1:0] a_in;
    logic                   b_en;
    logic [DIM*BITS_AB-1:0] b_in;
    logic                   sa_en, sa_wr_en;
    logic [RW-1:0]          sa_crow;
    logic [DIM*BITS_C-1:0]  sa_cin;
    logic [DIM*BITS_C-1:0]  sa_cout;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    tpu_mmio_seq #(
        .BITS_AB (BITS_AB),
        .BITS_C  (BITS_C),
        .DIM     (DIM),
        .ADDRW   (ADDRW),
        .DATAW   (DATAW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .r_w       (r_w),
        .addr      (addr),
        .dataIn    (dataIn),
        .dataOut   (dataOut),
        .rsp_valid (rsp_valid),
        .busy      (busy),
        .a_en      (a_en),
        .a_wr_en   (a_wr_en),
        .a_row     (a_row),
        .a_in      (a_in),
        .b_en      (b_en),
        .b_in      (b_in),
        .sa_en     (sa_en),
        .sa_wr_en  (sa_wr_en),
        .sa_crow   (sa_crow),
        .sa_cin    (sa_cin),
        .sa_cout   (sa_cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Stand-in for the array's C storage: row write, combinational row read.
    logic [DIM*BITS_C-1:0] cmem [DIM];
    initial for (int i = 0; i < DIM; i++) cmem[i] = '0;
    always @(posedge clk) if (sa_wr_en) cmem[sa_crow] <= sa_cin;
    assign sa_cout = cmem[sa_crow];

    // Read scoreboard: expected data with the cycle its response is due.
    typedef struct {
        int          due;
        logic [63:0] data;
        string       name;
    } exp_t;
    exp_t exp_q[$];

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            vectors++;
            if (!rsp_valid) begin
                miscompares++;
                $display("FAIL %s: rsp_valid=0 want 1", e.name);
            end else if (dataOut !== e.data) begin
                miscompares++;
                $display("FAIL %s: dataOut=%h want %h", e.name, dataOut, e.data);
            end else begin
                $display("ok   %s: dataOut=%h", e.name, dataOut);
            end
        end else if (rsp_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_rsp: rsp_valid=1 want 0 (cycle %0d)", cyc);
        end
    end

    // Activity counters over one sequencer run.
    int          busy_cnt, clr_cnt, mul_cnt, bad_wr;
    logic [7:0]  clr_rows;
    logic [RW-1:0] last_arow;
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (busy && sa_wr_en) begin
            clr_cnt++;
            clr_rows[sa_crow] = 1'b1;
        end
        if (sa_en) begin
            mul_cnt++;
            last_arow = a_row;
            if (a_wr_en) bad_wr++;
        end
    end

    task automatic clr_counters();
        busy_cnt = 0; clr_cnt = 0; mul_cnt = 0; bad_wr = 0;
        clr_rows = '0; last_arow = '0;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic start_op(input logic w, input logic [15:0] a, input logic [63:0] d);
        @(negedge clk);
        req = 1'b1; r_w = w; addr = a; dataIn = d;
        #1;
    endtask

    task automatic end_op();
        @(posedge clk);
        #1;
        req = 1'b0; r_w = 1'b0; addr = '0; dataIn = '0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [63:0] d);
        start_op(1'b1, a, d);
        end_op();
    endtask

    task automatic rd(input logic [15:0] a, input logic [63:0] expv, input string name);
        exp_t e;
        start_op(1'b0, a, '0);
        e.due = cyc + 1; e.data = expv; e.name = name;
        exp_q.push_back(e);
        end_op();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("idle_reached", {127'd0, busy}, 128'd0);
    endtask

    localparam logic [63:0] DA = 64'h0807060504030201;
    localparam logic [63:0] DB = 64'h1122334455667788;
    localparam logic [63:0] X  = 64'hAAAA_0000_BBBB_1111;
    localparam logic [63:0] Y  = 64'hCCCC_2222_DDDD_3333;
    localparam logic [63:0] P  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] Q  = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] R  = 64'h5555_6666_7777_8888;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 1'b0; r_w = 1'b0; addr = '0; dataIn = '0;
        clr_counters();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",      {127'd0, busy}, 128'd0);
        chk("rst_rsp_valid", {127'd0, rsp_valid}, 128'd0);
        chk("rst_dataOut",   {64'd0, dataOut}, 128'd0);
        chk("rst_strobes",   {124'd0, a_en, b_en, sa_en, sa_wr_en}, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // A write: strobes in the same cycle
        start_op(1'b1, 16'h0103, DA);
        chk("a_en_wr_en", {126'd0, a_en, a_wr_en}, 128'd3);
        chk("a_row",      {125'd0, a_row}, 128'd3);
        chk("a_in",       {64'd0, a_in}, {64'd0, DA});
        chk("a_no_b",     {126'd0, b_en, sa_wr_en}, 128'd0);
        end_op();

        // B push
        start_op(1'b1, 16'h0200, DB);
        chk("b_en",  {126'd0, b_en, a_en}, 128'd2);
        chk("b_in",  {64'd0, b_in}, {64'd0, DB});
        end_op();

        // C row 2, in order: word 0 stages, word 1 commits
        start_op(1'b1, 16'h0304, X);
        chk("c_w0_no_commit", {127'd0, sa_wr_en}, 128'd0);
        end_op();
        start_op(1'b1, 16'h0305, Y);
        chk("c_w1_commit", {127'd0, sa_wr_en}, 128'd1);
        chk("c_w1_crow",   {125'd0, sa_crow}, 128'd2);
        chk("c_w1_cin",    sa_cin, {Y, X});
        end_op();
        rd(16'h0305, Y, "rd_c2_w1");
        rd(16'h0304, X, "rd_c2_w0");

        // C row 3, out of order: top word first commits with the old staged word
        start_op(1'b1, 16'h0307, P);
        chk("ooo_commit", {124'd0, sa_wr_en, sa_crow}, {124'd0, 1'b1, 3'd3});
        chk("ooo_cin",    sa_cin, {P, X});
        end_op();
        start_op(1'b1, 16'h0306, Q);
        chk("ooo_w0_no_commit", {127'd0, sa_wr_en}, 128'd0);
        end_op();
        start_op(1'b1, 16'h0307, R);
        chk("ooo_cin2", sa_cin, {R, Q});
        end_op();
        rd(16'h0306, Q, "rd_c3_w0");
        rd(16'h0307, R, "rd_c3_w1");

        // Unmapped access
        start_op(1'b1, 16'h0500, DB);
        chk("unmapped_wr", {125'd0, a_en, b_en, sa_wr_en}, 128'd0);
        end_op();
        rd(16'h0500, 64'd0, "rd_unmapped");
        rd(16'h0401, 64'd0, "rd_status_idle");

        // Run 1: clear + multiply
        clr_counters();
        wr(16'h0400, 64'h3);
        wait_idle();
        chk("run1_busy_cycles",  busy_cnt, 128'd31);
        chk("run1_clear_cycles", clr_cnt, 128'd8);
        chk("run1_clear_rows",   {120'd0, clr_rows}, 128'hFF);
        chk("run1_mul_cycles",   mul_cnt, 128'd22);
        chk("run1_arow_hold",    {125'd0, last_arow}, 128'd7);
        chk("run1_no_a_write",   bad_wr, 128'd0);
        rd(16'h0305, 64'd0, "rd_c2_after_clear");
        rd(16'h0307, 64'd0, "rd_c3_after_clear");
        rd(16'h0401, 64'h2, "rd_status_done");
        rd(16'h0401, 64'h0, "rd_status_cleared");

        // Run 2: multiply only
        clr_counters();
        wr(16'h0400, 64'h1);
        wait_idle();
        chk("run2_busy_cycles",  busy_cnt, 128'd23);
        chk("run2_clear_cycles", clr_cnt, 128'd0);
        chk("run2_mul_cycles",   mul_cnt, 128'd22);
        rd(16'h0401, 64'h2, "rd_status_done2");

        // Run 3: host traffic while busy is rejected and flagged
        wr(16'h0304, X);
        wr(16'h0305, Y);
        clr_counters();
        wr(16'h0400, 64'h3);
        start_op(1'b1, 16'h0200, DB);
        chk("busy_b_no_push", {127'd0, b_en}, 128'd0);
        end_op();
        wr(16'h0400, 64'h1);
        rd(16'h0305, 64'd0, "rd_c_while_busy");
        wait_idle();
        chk("run3_busy_cycles", busy_cnt, 128'd31);
        rd(16'h0401, 64'h6, "rd_status_done_err");
        rd(16'h0401, 64'h0, "rd_status_cleared2");

        // Run 4: reset in the middle of a multiply
        wr(16'h0400, 64'h1);
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy",    {127'd0, busy}, 128'd0);
        chk("midrst_strobes", {123'd0, a_en, a_wr_en, b_en, sa_en, sa_wr_en}, 128'd0);
        chk("midrst_rows",    {122'd0, a_row, sa_crow}, 128'd0);
        chk("midrst_rsp",     {63'd0, rsp_valid, dataOut}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        rd(16'h0401, 64'h0, "rd_status_after_rst");

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
